// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone B4 pipelined arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_e;

  // Width of a counter that must hold values 0..max inclusive.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter with per-cycle bus locking
// and outstanding-response tracking so ack/err always reach the owning master.
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIXED_PRIO      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [AW-1:0]   s_adr_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i,
  input  logic [DW-1:0]   s_dat_i
);

  localparam int            CW    = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  arb_state_e    state_q;
  logic          last_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic req0, req1, own0, own1, own_cyc, own_stb;
  logic full, acc, rsp, fwd;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign own0 = (state_q == ARB_OWN0);
  assign own1 = (state_q == ARB_OWN1);

  assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign full    = (cnt_q == MAX_C);

  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_cyc & own_stb & ~full;
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : '0);
  assign s_we_o  = own0 ? m0_we_i  : (own1 ? m1_we_i  : 1'b0);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : '0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : '0);

  // A response with nothing outstanding is stray and dropped; nothing is
  // forwarded while reset is being applied.
  assign acc = s_stb_o & ~s_stall_i;
  assign rsp = (s_ack_i | s_err_i) & (cnt_q != '0);
  assign fwd = rsp & ~rst;

  assign m0_ack_o   = own0 & fwd & s_ack_i;
  assign m0_err_o   = own0 & fwd & s_err_i;
  assign m0_stall_o = ~own0 | s_stall_i | full;
  assign m0_dat_o   = s_dat_i;
  assign m1_ack_o   = own1 & fwd & s_ack_i;
  assign m1_err_o   = own1 & fwd & s_err_i;
  assign m1_stall_o = ~own1 | s_stall_i | full;
  assign m1_dat_o   = s_dat_i;

  // Dropping cyc aborts the cycle: any responses still in flight are forgotten.
  always_comb begin
    cnt_d = cnt_q;
    if (!own_cyc)          cnt_d = '0;
    else if (acc && !rsp)  cnt_d = cnt_q + CW'(1);
    else if (!acc && rsp)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      unique case (state_q)
        ARB_IDLE: begin
          if (req0 && (!req1 || (FIXED_PRIO != 0) || last_q)) begin
            state_q <= ARB_OWN0;
            last_q  <= 1'b0;
          end else if (req1) begin
            state_q <= ARB_OWN1;
            last_q  <= 1'b1;
          end
        end
        ARB_OWN0: if (!m0_cyc_i) state_q <= ARB_IDLE;
        ARB_OWN1: if (!m1_cyc_i) state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_cnt_max:   assert property (@(posedge clk) disable iff (rst) cnt_q <= MAX_C);
  a_stb_cyc:   assert property (@(posedge clk) disable iff (rst) s_stb_o |-> s_cyc_o);
  a_m0_noack:  assert property (@(posedge clk) disable iff (rst) !own0 |-> !(m0_ack_o || m0_err_o));
  a_m1_noack:  assert property (@(posedge clk) disable iff (rst) !own1 |-> !(m1_ack_o || m1_err_o));
`endif

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Scenario bench for wb_arbiter_2to1: a bench-side slave model feeds responses while
// a scoreboard queue holds the data each owning master should receive.
module tb_wb_arbiter_2to1;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  // Outputs of the fixed-priority instance
  logic        f0_ack, f0_err, f0_stall, f1_ack, f1_err, f1_stall;
  logic [31:0] f0_rdat, f1_rdat, fs_adr, fs_wdat;
  logic        fs_cyc, fs_stb, fs_we;
  logic [3:0]  fs_sel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.AW(32), .DW(32), .MAX_OUTSTANDING(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_adr_o(s_adr), .s_we_o(s_we), .s_sel_o(s_sel), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_rdat)
  );

  wb_arbiter_2to1 #(.AW(32), .DW(32), .MAX_OUTSTANDING(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_dat_i(m0_wdat), .m0_ack_o(f0_ack), .m0_err_o(f0_err), .m0_stall_o(f0_stall), .m0_dat_o(f0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_dat_i(m1_wdat), .m1_ack_o(f1_ack), .m1_err_o(f1_err), .m1_stall_o(f1_stall), .m1_dat_o(f1_rdat),
    .s_cyc_o(fs_cyc), .s_stb_o(fs_stb), .s_adr_o(fs_adr), .s_we_o(fs_we), .s_sel_o(fs_sel), .s_dat_o(fs_wdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_rdat)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] adr);
    return {adr[15:0], ~adr[15:0]};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
    nxt();                                  // grant to m0
    nxt();                                  // first beat accepted
    rst = 1; s_ack = 1; s_rdat = 32'h1111_2222;
    @(negedge clk);
    n_checks++; if (m0_ack !== 1'b0) begin $display("FAIL rst_ack_in_reset_cycle: got %b want 0", m0_ack); n_fail++; end
    nxt();
    @(negedge clk);
    n_checks++; if (s_cyc !== 1'b0) begin $display("FAIL rst_s_cyc: got %b want 0", s_cyc); n_fail++; end
    n_checks++; if (m0_ack !== 1'b0) begin $display("FAIL rst_ack_after: got %b want 0", m0_ack); n_fail++; end
    nxt();
    rst = 0;
    @(negedge clk);
    n_checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin $display("FAIL rel_s_cyc_stb: got %b%b want 00", s_cyc, s_stb); n_fail++; end
    n_checks++; if (m0_stall !== 1'b1 || m1_stall !== 1'b1) begin $display("FAIL rel_stall: got %b%b want 11", m0_stall, m1_stall); n_fail++; end
    n_checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin $display("FAIL rel_ack: got %b%b want 00", m0_ack, m1_ack); n_fail++; end
    n_checks++; if (int'(dut.cnt_q) != 0) begin $display("FAIL rel_count: got %0d want 0", dut.cnt_q); n_fail++; end
    nxt();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    nxt();
    nxt();
  endtask

  task automatic test_single_read();
    bit m0_seen;
    m0_seen = 0;
    exp_q.delete();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_1000; m1_we = 0;
    @(negedge clk);
    n_checks++; if (s_stb !== 1'b0 || m1_stall !== 1'b1) begin $display("FAIL rd_latency: stb/stall got %b%b want 01", s_stb, m1_stall); n_fail++; end
    nxt();
    @(negedge clk);
    n_checks++; if (s_stb !== 1'b1 || s_cyc !== 1'b1) begin $display("FAIL rd_stb_cycle2: got %b%b want 11", s_cyc, s_stb); n_fail++; end
    n_checks++; if (s_adr !== 32'h0000_1000) begin $display("FAIL rd_adr: got %h want 00001000", s_adr); n_fail++; end
    if (s_stb && !s_stall) exp_q.push_back(32'hDEAD_BEEF);
    if (m0_ack) m0_seen = 1;
    nxt();
    m1_stb = 0; s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b1) begin $display("FAIL rd_m1_ack: got %b want 1", m1_ack); n_fail++; end
    if (m1_ack) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      n_checks++; if (m1_rdat !== e) begin $display("FAIL rd_m1_data: got %h want %h", m1_rdat, e); n_fail++; end
    end
    if (m0_ack) m0_seen = 1;
    nxt();
    s_ack = 0; m1_cyc = 0;
    @(negedge clk);
    if (m0_ack) m0_seen = 1;
    nxt();
    @(negedge clk);
    n_checks++; if (dut.state_q !== ARB_IDLE || s_cyc !== 1'b0) begin $display("FAIL rd_idle: state %0d cyc %b want IDLE,0", dut.state_q, s_cyc); n_fail++; end
    n_checks++; if (m0_seen !== 1'b0) begin $display("FAIL rd_m0_never_ack: got %b want 0", m0_seen); n_fail++; end
    nxt();
  endtask

  task automatic test_contention();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_A000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_B000;
    nxt();
    @(negedge clk);
    n_checks++; if (m0_stall !== 1'b0 || m1_stall !== 1'b1) begin $display("FAIL ct_first_rr: stall m0/m1 got %b%b want 01", m0_stall, m1_stall); n_fail++; end
    n_checks++; if (s_adr !== 32'h0000_A000) begin $display("FAIL ct_first_adr: got %h want 0000a000", s_adr); n_fail++; end
    n_checks++; if (f0_stall !== 1'b0 || f1_stall !== 1'b1) begin $display("FAIL ct_first_fp: stall got %b%b want 01", f0_stall, f1_stall); n_fail++; end
    nxt();
    m0_cyc = 0; m0_stb = 0;                 // m0 releases, m1 still waiting
    @(negedge clk);
    n_checks++; if (s_cyc !== 1'b0) begin $display("FAIL ct_release_cyc: got %b want 0", s_cyc); n_fail++; end
    nxt();
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    n_checks++; if (s_cyc !== 1'b0 || m1_stall !== 1'b1) begin $display("FAIL ct_idle_gap: cyc/m1stall got %b%b want 01", s_cyc, m1_stall); n_fail++; end
    nxt();
    @(negedge clk);
    n_checks++; if (m1_stall !== 1'b0 || m0_stall !== 1'b1) begin $display("FAIL ct_second_rr: stall m0/m1 got %b%b want 10", m0_stall, m1_stall); n_fail++; end
    n_checks++; if (s_adr !== 32'h0000_B000) begin $display("FAIL ct_second_adr: got %h want 0000b000", s_adr); n_fail++; end
    n_checks++; if (f0_stall !== 1'b0 || fs_adr !== 32'h0000_A000) begin $display("FAIL ct_second_fp: m0stall %b adr %h want 0,0000a000", f0_stall, fs_adr); n_fail++; end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    nxt();
    nxt();
  endtask

  task automatic test_back_to_back();
    int issued, acks;
    bit m1_seen;
    issued = 0; acks = 0; m1_seen = 0;
    exp_q.delete(); pend_q.delete();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_2000; s_stall = 0; s_ack = 0;
    nxt();
    for (int c = 0; c < 40 && acks < 6; c++) begin
      m0_stb = (issued < 6);
      m0_adr = 32'h0000_2000 + 32'(4 * issued);
      s_ack  = 0;
      if (c >= 8 && pend_q.size() > 0) begin
        s_ack = 1; s_rdat = slave_data(pend_q.pop_front());
      end
      @(negedge clk);
      if (m1_ack) m1_seen = 1;
      if (c == 7) begin
        n_checks++; if (issued != 4) begin $display("FAIL b2b_accepted_limit: got %0d want 4", issued); n_fail++; end
        n_checks++; if (m0_stall !== 1'b1) begin $display("FAIL b2b_stall_full: got %b want 1", m0_stall); n_fail++; end
        n_checks++; if (int'(dut.cnt_q) != 4) begin $display("FAIL b2b_count_full: got %0d want 4", dut.cnt_q); n_fail++; end
      end
      if (m0_ack) begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        acks++;
        n_checks++; if (m0_rdat !== e) begin $display("FAIL b2b_data%0d: got %h want %h", acks, m0_rdat, e); n_fail++; end
      end
      if (s_stb && !s_stall) begin
        pend_q.push_back(s_adr);
        exp_q.push_back(slave_data(s_adr));
      end
      if (m0_stb && !m0_stall) issued++;
      nxt();
    end
    n_checks++; if (acks != 6 || issued != 6) begin $display("FAIL b2b_totals: acks %0d issued %0d want 6 6", acks, issued); n_fail++; end
    n_checks++; if (m1_seen !== 1'b0 || exp_q.size() != 0) begin $display("FAIL b2b_routing: m1ack %b left %0d want 0 0", m1_seen, exp_q.size()); n_fail++; end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    nxt();
    nxt();
  endtask

  task automatic test_abort();
    exp_q.delete(); pend_q.delete();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_3000;
    nxt();
    for (int b = 0; b < 3; b++) begin
      m1_adr = 32'h0000_3000 + 32'(4 * b);
      @(negedge clk);
      n_checks++; if (s_stb !== 1'b1) begin $display("FAIL ab_beat%0d_stb: got %b want 1", b, s_stb); n_fail++; end
      if (s_stb && !s_stall) begin pend_q.push_back(s_adr); exp_q.push_back(slave_data(s_adr)); end
      nxt();
    end
    m1_stb = 0; s_ack = 1;
    s_rdat = (pend_q.size() > 0) ? slave_data(pend_q.pop_front()) : 32'h0;
    @(negedge clk);
    begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      n_checks++; if (m1_ack !== 1'b1 || m1_rdat !== e) begin $display("FAIL ab_first_ack: ack %b data %h want 1 %h", m1_ack, m1_rdat, e); n_fail++; end
    end
    nxt();
    m1_cyc = 0; s_ack = 0;
    @(negedge clk);
    n_checks++; if (s_cyc !== 1'b0) begin $display("FAIL ab_cyc_drop: got %b want 0", s_cyc); n_fail++; end
    nxt();
    for (int k = 0; k < 2; k++) begin
      s_ack = 1;
      s_rdat = (pend_q.size() > 0) ? slave_data(pend_q.pop_front()) : 32'h0;
      @(negedge clk);
      n_checks++; if (dut.state_q !== ARB_IDLE || int'(dut.cnt_q) != 0) begin $display("FAIL ab_idle%0d: state %0d cnt %0d want IDLE 0", k, dut.state_q, dut.cnt_q); n_fail++; end
      n_checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin $display("FAIL ab_late_ack%0d: got %b%b want 00", k, m0_ack, m1_ack); n_fail++; end
      nxt();
    end
    s_ack = 0;
    nxt();
  endtask

  task automatic test_ack_err();
    int errs;
    errs = 0;
    exp_q.delete(); pend_q.delete();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_4000;
    nxt();
    for (int b = 0; b < 4; b++) begin
      m0_adr = 32'h0000_4000 + 32'(4 * b);
      s_ack = 0;
      if (b == 3) begin
        s_ack = 1;
        s_rdat = (pend_q.size() > 0) ? slave_data(pend_q.pop_front()) : 32'h0;
      end
      @(negedge clk);
      if (b == 3) begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_checks++; if (int'(dut.cnt_q) != 3 || s_stb !== 1'b1) begin $display("FAIL ae_pre: cnt %0d stb %b want 3 1", dut.cnt_q, s_stb); n_fail++; end
        n_checks++; if (m0_ack !== 1'b1 || m0_rdat !== e) begin $display("FAIL ae_ack1: ack %b data %h want 1 %h", m0_ack, m0_rdat, e); n_fail++; end
      end
      if (m0_err) errs++;
      if (s_stb && !s_stall) begin pend_q.push_back(s_adr); exp_q.push_back(slave_data(s_adr)); end
      nxt();
    end
    m0_stb = 0; s_ack = 0; s_err = 1;
    void'(pend_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    n_checks++; if (int'(dut.cnt_q) != 3) begin $display("FAIL ae_count_steady: got %0d want 3", dut.cnt_q); n_fail++; end
    n_checks++; if (m0_err !== 1'b1 || m0_ack !== 1'b0) begin $display("FAIL ae_err_beat2: err %b ack %b want 1 0", m0_err, m0_ack); n_fail++; end
    if (m0_err) errs++;
    nxt();
    s_err = 0;
    for (int k = 0; k < 2; k++) begin
      s_ack = 1;
      s_rdat = (pend_q.size() > 0) ? slave_data(pend_q.pop_front()) : 32'h0;
      @(negedge clk);
      if (k == 0) begin
        n_checks++; if (int'(dut.cnt_q) != 2) begin $display("FAIL ae_count_after_err: got %0d want 2", dut.cnt_q); n_fail++; end
      end
      begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_checks++; if (m0_ack !== 1'b1 || m0_rdat !== e) begin $display("FAIL ae_tail%0d: ack %b data %h want 1 %h", k, m0_ack, m0_rdat, e); n_fail++; end
      end
      if (m0_err) errs++;
      nxt();
    end
    s_ack = 0;
    @(negedge clk);
    n_checks++; if (errs != 1 || int'(dut.cnt_q) != 0) begin $display("FAIL ae_err_once: errs %0d cnt %0d want 1 0", errs, dut.cnt_q); n_fail++; end
    m0_cyc = 0;
    nxt();
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    m0_cyc = 0; m0_stb = 0; m0_adr = '0; m0_we = 0; m0_sel = 4'hF; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_adr = '0; m1_we = 0; m1_sel = 4'hF; m1_wdat = '0;
    s_ack = 0; s_err = 0; s_stall = 0; s_rdat = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    nxt();
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_abort();
    test_ack_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
